// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding and PC constants.
package fetch_pkg;

    localparam int PC_WIDTH = 32;
    localparam logic [PC_WIDTH-1:0] PC_STEP        = 32'd4;
    localparam logic [PC_WIDTH-1:0] PC_READ_OFFSET = 32'd8;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory request side plus instruction hand-off to the controller.
interface instr_fetch_if;
    import fetch_pkg::*;

    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ready;
    logic [31:0]         imem_rdata;
    logic                instr_valid;
    logic                instr_ready;
    logic [31:0]         instr;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_plus8;
    logic                pc_src;
    logic [PC_WIDTH-1:0] branch_target;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, pc, pc_plus8,
        input  imem_ready, imem_rdata, instr_ready, pc_src, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, pc, pc_plus8,
        output imem_ready, imem_rdata, instr_ready, pc_src, branch_target
    );

endinterface

// File: rtl/pc_next.sv
// Next fetch address: sequential step or word-aligned branch redirect.
module pc_next
    import fetch_pkg::*;
(
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic                i_pc_src,
    input  logic [PC_WIDTH-1:0] i_branch_target,
    output logic [PC_WIDTH-1:0] o_next_pc
);

    logic [PC_WIDTH-1:0] w_target;

    // Low target bits are dropped so redirects always land on a word boundary.
    assign w_target  = i_branch_target & ~(PC_WIDTH'(3));
    assign o_next_pc = i_pc_src ? w_target : i_pc + PC_STEP;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding request, holds the fetched word until the consumer takes it.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    instr_fetch_if.master bus
);

    localparam logic [PC_WIDTH-1:0] RESET_PC_AL = {RESET_PC[PC_WIDTH-1:2], 2'b00};

    fetch_state_t        r_state;
    fetch_state_t        w_state_nxt;
    logic [PC_WIDTH-1:0] r_fetch_pc;
    logic [PC_WIDTH-1:0] r_pc;
    logic [31:0]         r_instr;
    logic [PC_WIDTH-1:0] w_next_pc;
    logic                w_req;
    logic                w_valid;
    logic                w_consume;
    logic                w_accept;

    pc_next u_pc_next (
        .i_pc            (r_pc),
        .i_pc_src        (bus.pc_src),
        .i_branch_target (bus.branch_target),
        .o_next_pc       (w_next_pc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_valid     = 1'b0;
        unique case (r_state)
            ST_RST: w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                w_req = 1'b1;
                if (bus.imem_ready) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                w_valid = 1'b1;
                if (bus.instr_ready) w_state_nxt = ST_FETCH;
            end
            default: w_state_nxt = ST_RST;
        endcase
    end

    assign w_accept  = w_req & bus.imem_ready;
    assign w_consume = w_valid & bus.instr_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_RST;
            r_fetch_pc <= RESET_PC_AL;
            r_pc       <= RESET_PC_AL;
            r_instr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_RST) r_fetch_pc <= RESET_PC_AL;
            if (w_accept) begin
                r_instr <= bus.imem_rdata;
                r_pc    <= r_fetch_pc;
            end
            // Redirect inputs only matter at the moment the held instruction leaves.
            if (w_consume) r_fetch_pc <= w_next_pc;
        end
    end

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = r_fetch_pc;
    assign bus.instr_valid = w_valid;
    assign bus.instr       = r_instr;
    assign bus.pc          = r_pc;
    assign bus.pc_plus8    = r_pc + PC_READ_OFFSET;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, memory stalls, hold/redirect, wrap and reset abandonment.
module tb_instr_fetch;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b0;
        bus.imem_ready    = 1'b1;
        bus.imem_rdata    = 32'h0;
        bus.instr_ready   = 1'b1;
        bus.pc_src        = 1'b0;
        bus.branch_target = 32'h0;
        tick();
        tick();
        chk("rst_req",   32'(bus.imem_req), 32'd0);
        chk("rst_vld",   32'(bus.instr_valid), 32'd0);
        chk("rst_pc",    bus.pc, 32'h0);
        chk("rst_instr", bus.instr, 32'h0);

        // First cycle after release is still RST, fetch starts the cycle after.
        reset = 1'b1;
        chk("rel_req", 32'(bus.imem_req), 32'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("seq_req",  32'(bus.imem_req), 32'd1);
            chk("seq_addr", bus.imem_addr, 32'(k * 4));
            chk("seq_vld0", 32'(bus.instr_valid), 32'd0);
            bus.imem_rdata = 32'h1000_0000 + 32'(k);
            tick();
            chk("seq_vld1",  32'(bus.instr_valid), 32'd1);
            chk("seq_hreq",  32'(bus.imem_req), 32'd0);
            chk("seq_pc",    bus.pc, 32'(k * 4));
            chk("seq_instr", bus.instr, 32'h1000_0000 + 32'(k));
            chk("seq_pc8",   bus.pc_plus8, 32'(k * 4 + 8));
            tick();
        end

        // Walk 0xC -> 0x10, then stall the memory there.
        tick();
        tick();
        chk("stl_addr0", bus.imem_addr, 32'h10);
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'hBAD0_BAD0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stl_req",  32'(bus.imem_req), 32'd1);
            chk("stl_addr", bus.imem_addr, 32'h10);
            chk("stl_vld",  32'(bus.instr_valid), 32'd0);
        end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hCAFE_0010;
        tick();
        chk("stl_done_vld",   32'(bus.instr_valid), 32'd1);
        chk("stl_done_pc",    bus.pc, 32'h10);
        chk("stl_done_instr", bus.instr, 32'hCAFE_0010);

        // Held instruction ignores redirect inputs and stray memory data.
        bus.instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.pc_src        = k[0];
            bus.branch_target = 32'h400 + 32'(k * 4);
            bus.imem_rdata    = 32'hDEAD_BEEF;
            tick();
            chk("hold_vld",   32'(bus.instr_valid), 32'd1);
            chk("hold_pc",    bus.pc, 32'h10);
            chk("hold_instr", bus.instr, 32'hCAFE_0010);
        end
        bus.instr_ready   = 1'b1;
        bus.pc_src        = 1'b1;
        bus.branch_target = 32'h0000_0103;
        tick();
        chk("br_req",  32'(bus.imem_req), 32'd1);
        chk("br_addr", bus.imem_addr, 32'h100);
        bus.pc_src     = 1'b0;
        bus.imem_rdata = 32'h0000_0100;
        tick();
        chk("br_pc", bus.pc, 32'h100);

        // Redirect to the top word, then let the PC wrap.
        bus.pc_src        = 1'b1;
        bus.branch_target = 32'hFFFF_FFFF;
        tick();
        chk("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        bus.pc_src     = 1'b0;
        bus.imem_rdata = 32'h5555_AAAA;
        tick();
        chk("top_pc",  bus.pc, 32'hFFFF_FFFC);
        chk("top_pc8", bus.pc_plus8, 32'h0000_0004);
        tick();
        chk("wrap_req",  32'(bus.imem_req), 32'd1);
        chk("wrap_addr", bus.imem_addr, 32'h0);

        // Reset while a request is outstanding.
        reset = 1'b0;
        tick();
        chk("rf_req",   32'(bus.imem_req), 32'd0);
        chk("rf_vld",   32'(bus.instr_valid), 32'd0);
        chk("rf_pc",    bus.pc, 32'h0);
        chk("rf_instr", bus.instr, 32'h0);
        reset = 1'b1;
        chk("rf_rel_req", 32'(bus.imem_req), 32'd0);
        tick();
        chk("rf_re_req",  32'(bus.imem_req), 32'd1);
        chk("rf_re_addr", bus.imem_addr, 32'h0);

        // Reach HOLD at 0x200, then reset while holding.
        bus.imem_rdata = 32'h0000_0077;
        tick();
        bus.pc_src        = 1'b1;
        bus.branch_target = 32'h0000_0200;
        tick();
        chk("rh_addr", bus.imem_addr, 32'h200);
        bus.pc_src      = 1'b0;
        bus.imem_rdata  = 32'h0000_0088;
        bus.instr_ready = 1'b0;
        tick();
        chk("rh_pc",    bus.pc, 32'h200);
        chk("rh_instr", bus.instr, 32'h0000_0088);
        reset = 1'b0;
        tick();
        chk("rh_req",   32'(bus.imem_req), 32'd0);
        chk("rh_vld",   32'(bus.instr_valid), 32'd0);
        chk("rh_pc0",   bus.pc, 32'h0);
        chk("rh_inst0", bus.instr, 32'h0);
        reset = 1'b1;
        chk("rh_rel_req", 32'(bus.imem_req), 32'd0);
        tick();
        chk("rh_re_req",  32'(bus.imem_req), 32'd1);
        chk("rh_re_addr", bus.imem_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  word-aligned fetch address, stable while imem_req=1.
REQ-006 imem_ready  input  1  memory accepts request and returns imem_rdata in the same cycle.
REQ-007 imem_rdata  input  32  fetched instruction word, valid only when imem_req & imem_ready.
REQ-008 instr_valid  output  1  instr/pc hold a fetched instruction for the controller/datapath.
REQ-009 instr_ready  input  1  consumer accepts instruction this cycle.
REQ-010 instr  output  32  held instruction; bits [31:12] drive the controller's instruction field.
REQ-011 pc  output  32  address of held instruction.
REQ-012 pc_plus8  output  32  pc+8 (architectural R15 read value).
REQ-013 pc_src  input  1  controller branch decision for the held instruction, sampled only on a consume.
REQ-014 branch_target  input  32  redirect address, sampled only on a consume with pc_src=1.

Function
REQ-015 FSM states: RST, FETCH, HOLD; encoding SHALL come from the shared package.
REQ-016 RST: imem_req=0, instr_valid=0; next state FETCH with fetch address RESET_PC.
REQ-017 FETCH: imem_req=1, imem_addr=fetch PC; on imem_ready=1, capture imem_rdata into instr, fetch PC into pc, go HOLD; else stay FETCH with address unchanged.
REQ-018 HOLD: instr_valid=1, imem_req=0; instr and pc SHALL not change until consume.
REQ-019 Consume = instr_valid & instr_ready; on consume go FETCH with next PC = pc_src ? {branch_target[31:2],2'b00} : pc+4.
REQ-020 Without consume, HOLD persists indefinitely; pc_src/branch_target SHALL be ignored.
REQ-021 Fetch latency: a request completing in cycle N gives instr_valid=1 in cycle N+1; minimum throughput one instruction per two cycles.
REQ-022 PC arithmetic modulo 2^32: pc=32'hFFFF_FFFC, no branch -> next fetch address 32'h0000_0000.
REQ-023 branch_target[1:0] SHALL be forced to 2'b00; pc and imem_addr bits [1:0] always 0.
REQ-024 pc_plus8 = pc+8 modulo 2^32, combinational from pc.
REQ-025 imem_rdata outside FETCH, or in FETCH with imem_ready=0, SHALL be ignored.

Reset
REQ-026 While reset=0 at a rising edge: state->RST, imem_req=0, instr_valid=0, instr=0, pc=RESET_PC, fetch PC=RESET_PC.
REQ-027 Reset in FETCH or HOLD SHALL abandon the request/held instruction; no consume or redirect is recorded.
REQ-028 First cycle after reset=1 is RST; imem_req=1 with imem_addr=RESET_PC in the following cycle.

Structure
REQ-029 Package fetch_pkg SHALL hold the state enum, PC_WIDTH=32, PC_STEP=4, PC_READ_OFFSET=8.
REQ-030 One sub-module pc_next SHALL compute the next fetch address (pc, pc_src, branch_target -> next_pc); the rest stays flat.
REQ-031 All registers SHALL use single always_ff on clk with synchronous active-low reset; no latches.

Verification
REQ-032 Reset release, imem_ready=1, instr_ready=1: imem_addr sequence 0,4,8 every second cycle; instr_valid alternates 0/1.
REQ-033 imem_ready held 0 for 3 cycles at addr 0x10: imem_addr stays 0x10, instr_valid=0; ready=1 -> next cycle instr_valid=1, pc=0x10.
REQ-034 HOLD with instr_ready=0 for 5 cycles, pc_src toggling: instr/pc unchanged; consume with pc_src=1, branch_target=0x0000_0103 -> next imem_addr=0x100.
REQ-035 pc=0xFFFF_FFFC consumed with pc_src=0: next imem_addr=0x0000_0000; pc_plus8 for that pc = 0x0000_0004.
REQ-036 reset=0 asserted in FETCH and in HOLD: next cycle imem_req=0, instr_valid=0, pc=RESET_PC; restart fetches RESET_PC.
REQ-037 imem_rdata=0xDEAD_BEEF driven in HOLD: instr unchanged.
